// File: rtl/color_sel_input_pkg.sv
// Shared definitions for the colour-select input front end and the LED colour driver.
package color_sel_input_pkg;

    // Colour codes, common to this block and the RGB LED driver.
    localparam logic [1:0] SEL_WHITE  = 2'b00;
    localparam logic [1:0] SEL_RED    = 2'b01;
    localparam logic [1:0] SEL_GREEN  = 2'b10;
    localparam logic [1:0] SEL_YELLOW = 2'b11;

    // Meaning of the debounced mode switch.
    typedef enum logic {
        ModeSwitch = 1'b0,
        ModeButton = 1'b1
    } sel_mode_e;

    // Conditioned input bundle; packed so each bit can go through its own debouncer.
    // Bit order: [0] btn_next, [1] btn_prev, [3:2] sw, [4] mode.
    typedef struct packed {
        logic       mode;
        logic [1:0] sw;
        logic       btn_prev;
        logic       btn_next;
    } cond_in_t;

    localparam int unsigned NUM_INPUTS = $bits(cond_in_t);

    // One button-mode step: next/prev presses walk the code modulo 4, both or neither hold.
    function automatic logic [1:0] sel_step(input logic [1:0] cur,
                                            input logic       up,
                                            input logic       down);
        logic [1:0] nxt;
        nxt = cur;
        if (up && !down) begin
            nxt = cur + 2'd1;
        end else if (down && !up) begin
            nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw input bit.
module debounce_sync #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    // Reject parameter sets the counter cannot represent.
    if (DEBOUNCE_CYCLES < 2 || (64'(1) << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_params
        $error("debounce_sync: need DEBOUNCE_CYCLES >= 2 and 2**CNT_W >= DEBOUNCE_CYCLES");
    end

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accept s2 only after it has disagreed with the held level for DEBOUNCE_CYCLES cycles;
    // any return to the held level restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            stable_d = s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Synchroniser, debounced level and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= din;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/color_sel_input.sv
// Colour-select front end: conditions buttons/switches and drives the 2-bit LED colour code.
module color_sel_input
    import color_sel_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic [1:0] sw_raw,
    input  logic       mode_raw,
    output logic [1:0] sel,
    output logic       sel_chg
);

    cond_in_t                raw_in;
    cond_in_t                stable_in;
    logic [NUM_INPUTS-1:0]   raw_vec;
    logic [NUM_INPUTS-1:0]   stable_vec;

    logic                    next_dly_q, prev_dly_q;
    logic                    press_next, press_prev;
    sel_mode_e               mode;
    logic [1:0]              sel_q, sel_d;
    logic                    sel_chg_q, sel_chg_d;

    // Gather the raw pins into the packed bundle.
    always_comb begin
        raw_in          = '0;
        raw_in.btn_next = btn_next;
        raw_in.btn_prev = btn_prev;
        raw_in.sw       = sw_raw;
        raw_in.mode     = mode_raw;
    end

    assign raw_vec   = raw_in;
    assign stable_in = cond_in_t'(stable_vec);

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_cond
        debounce_sync #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .din  (raw_vec[i]),
            .dout (stable_vec[i])
        );
    end

    // Rising edge of each debounced button is one press; releases are ignored.
    assign press_next = stable_in.btn_next & ~next_dly_q;
    assign press_prev = stable_in.btn_prev & ~prev_dly_q;
    assign mode       = sel_mode_e'(stable_in.mode);

    // Next select code and the change strobe that accompanies it.
    always_comb begin
        sel_d = sel_q;
        unique case (mode)
            ModeSwitch: sel_d = stable_in.sw;
            ModeButton: sel_d = sel_step(sel_q, press_next, press_prev);
            default:    sel_d = sel_q;
        endcase
        // Strobe only on a real change, not on a write of the same value.
        sel_chg_d = (sel_d != sel_q);
    end

    // Button edge-detect delay, select register and change strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            next_dly_q <= 1'b0;
            prev_dly_q <= 1'b0;
            sel_q      <= SEL_WHITE;
            sel_chg_q  <= 1'b0;
        end else begin
            next_dly_q <= stable_in.btn_next;
            prev_dly_q <= stable_in.btn_prev;
            sel_q      <= sel_d;
            sel_chg_q  <= sel_chg_d;
        end
    end

    assign sel     = sel_q;
    assign sel_chg = sel_chg_q;

endmodule

// File: tb/tb_color_sel_input.sv
// Self-checking bench for color_sel_input: window-based reference model plus directed scenarios.
module tb_color_sel_input;
    import color_sel_input_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int unsigned CW  = 3;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic [1:0] sw_raw   = 2'b00;
    logic       mode_raw = 1'b0;
    logic [1:0] sel;
    logic       sel_chg;

    int n_checks  = 0;
    int n_fail    = 0;
    int chg_seen  = 0;
    int base      = 0;

    always #5 clk = ~clk;

    color_sel_input #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_next (btn_next),
        .btn_prev (btn_prev),
        .sw_raw   (sw_raw),
        .mode_raw (mode_raw),
        .sel      (sel),
        .sel_chg  (sel_chg)
    );

    // ---------------- reference model ----------------
    // Input index: 0 next, 1 prev, 2 sw[0], 3 sw[1], 4 mode.
    bit         m_s1[5];
    bit         m_s2[5];
    bit         m_lvl[5];
    bit         m_lvl_prev[5];
    bit         hist[5][$];
    logic [1:0] m_sel = 2'b00;
    logic       m_chg = 1'b0;

    task automatic model_clear();
        for (int i = 0; i < 5; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_lvl_prev[i] = 0;
            hist[i].delete();
            for (int j = 0; j < int'(DEB); j++) hist[i].push_back(1'b0);
        end
        m_sel = 2'b00;
        m_chg = 1'b0;
    endtask

    task automatic model_step();
        bit [4:0]   raw;
        bit         nlvl[5];
        bit         all_diff, pn, pp;
        logic [1:0] nsel;
        raw = {mode_raw, sw_raw, btn_prev, btn_next};
        // A level is accepted once the last DEB synchronised samples all disagree with it.
        for (int i = 0; i < 5; i++) begin
            all_diff = 1;
            for (int j = 0; j < int'(DEB); j++)
                if (hist[i][hist[i].size() - 1 - j] == m_lvl[i]) all_diff = 0;
            nlvl[i] = all_diff ? ~m_lvl[i] : m_lvl[i];
        end
        pn = m_lvl[0] && !m_lvl_prev[0];
        pp = m_lvl[1] && !m_lvl_prev[1];
        if (!m_lvl[4])        nsel = {m_lvl[3], m_lvl[2]};
        else if (pn && !pp)   nsel = 2'(m_sel + 2'd1);
        else if (pp && !pn)   nsel = 2'(m_sel - 2'd1);
        else                  nsel = m_sel;
        m_chg = (nsel != m_sel);
        m_sel = nsel;
        for (int i = 0; i < 5; i++) begin
            m_lvl_prev[i] = m_lvl[i];
            m_lvl[i]      = nlvl[i];
            m_s2[i]       = m_s1[i];
            m_s1[i]       = raw[i];
            hist[i].push_back(m_s2[i]);
            while (hist[i].size() > int'(DEB)) void'(hist[i].pop_front());
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_clear();
            else      model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of DUT against the model, plus a strobe tally.
    initial begin
        forever begin
            @(negedge clk);
            check("model_sel", sel, m_sel);
            check("model_chg", {1'b0, sel_chg}, {1'b0, m_chg});
            if (sel_chg === 1'b1) chg_seen++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Literal expectation on sel (DUT and model) and on the number of strobes since base.
    task automatic expect_lit(input string name, input logic [1:0] exp_sel, input int pulses);
        check({name, "_sel"}, sel, exp_sel);
        check({name, "_model"}, m_sel, exp_sel);
        check_int({name, "_pulses"}, chg_seen - base, pulses);
        base = chg_seen;
    endtask

    task automatic press(input bit nxt, input bit prv, input int hold);
        @(negedge clk);
        btn_next = nxt;
        btn_prev = prv;
        cycles(hold);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        cycles(12);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // 1. Reset with random inputs.
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            btn_next = 1'($urandom); btn_prev = 1'($urandom);
            sw_raw   = 2'($urandom); mode_raw = 1'($urandom);
        end
        check("rst_sel", sel, SEL_WHITE);
        check("rst_chg", {1'b0, sel_chg}, 2'b00);
        @(negedge clk);
        btn_next = 0; btn_prev = 0; sw_raw = 2'b00; mode_raw = 0;
        #2 rst = 1'b1;
        cycles(20);
        base = chg_seen;
        expect_lit("idle", SEL_WHITE, 0);

        // 2. Switch mode: 00 -> 10 with exact latency.
        @(negedge clk);
        sw_raw = 2'b10;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1 check("sw_early", sel, SEL_WHITE);
        @(posedge clk);
        #1 check("sw_sel", sel, SEL_GREEN);
        check("sw_chg", {1'b0, sel_chg}, 2'b01);
        @(posedge clk);
        #1 check("sw_chg_end", {1'b0, sel_chg}, 2'b00);
        @(negedge clk);
        sw_raw = 2'b10;
        cycles(12);
        expect_lit("sw_same", SEL_GREEN, 1);

        // 3. Button mode: glitch rejected, long press steps once.
        mode_raw = 1'b1;
        cycles(12);
        expect_lit("to_btn", SEL_GREEN, 0);
        press(1, 0, 3);
        expect_lit("glitch", SEL_GREEN, 0);
        press(1, 0, 10);
        expect_lit("next", SEL_YELLOW, 1);

        // 4. Wrap both ways.
        press(1, 0, 8);
        expect_lit("wrap_up", SEL_WHITE, 1);
        press(0, 1, 8);
        expect_lit("wrap_dn", SEL_YELLOW, 1);

        // 5. Simultaneous presses cancel.
        press(1, 1, 10);
        expect_lit("both", SEL_YELLOW, 0);

        // 6. Mode back to switches, then reset mid-press.
        sw_raw = 2'b01;
        cycles(12);
        expect_lit("sw_btnmode", SEL_YELLOW, 0);
        mode_raw = 1'b0;
        cycles(12);
        expect_lit("to_sw", SEL_RED, 1);
        mode_raw = 1'b1;
        cycles(12);
        expect_lit("to_btn2", SEL_RED, 0);
        btn_next = 1'b1;
        cycles(3);
        #3 rst = 1'b0;
        #1 check("async_rst_sel", sel, SEL_WHITE);
        check("async_rst_chg", {1'b0, sel_chg}, 2'b00);
        base = chg_seen;
        @(negedge clk);
        #2 rst = 1'b1;
        cycles(14);
        expect_lit("held_after_rst", SEL_RED, 1);
        btn_next = 1'b0;
        cycles(10);

        // 7. Random traffic with occasional resets, checked by the model every cycle.
        for (int it = 0; it < 400; it++) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0) begin
                #2 rst = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #2 rst = 1'b1;
            end else begin
                case ($urandom_range(0, 3))
                    0: btn_next = ~btn_next;
                    1: btn_prev = ~btn_prev;
                    2: sw_raw   = 2'($urandom_range(0, 3));
                    default: if ($urandom_range(0, 3) == 0) mode_raw = ~mode_raw;
                endcase
                repeat ($urandom_range(0, 8)) @(negedge clk);
            end
        end

        cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
